// File: rtl/or4_serial_unit_if.sv
// Operand/result bundle for or4_serial_unit: start request with operands in,
// busy/done handshake, parallel result and serial result stream out.
interface or4_serial_unit_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] S;
    logic       bit_out;
    logic       bit_valid;
    logic [1:0] bit_idx;

    // Operand-entry side: issues requests, observes the result.
    modport master (
        output start, A, B,
        input  busy, done, S, bit_out, bit_valid, bit_idx
    );

    // Serial unit side.
    modport slave (
        input  start, A, B,
        output busy, done, S, bit_out, bit_valid, bit_idx
    );
endinterface

// File: rtl/or4_serial_unit.sv
// Bit-serial 4-bit OR unit. Latches A/B on an accepted start, produces one
// result bit per cycle through a single 1-bit OR stage, then presents the
// assembled result on S with a one-cycle done pulse.
// Build option: OR4_SERIAL_MSB_FIRST_EN selects MSB-first bit order
// (bit_idx 3,2,1,0); default is LSB-first (bit_idx 0,1,2,3).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs quiet, S holds last result
// RUN   | four cycles, one serial result bit per cycle
// DONE  | one cycle, done pulse, S carries the new result
module or4_serial_unit (
    input  logic             clk,
    input  logic             reset,
    or4_serial_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [3:0] a_sh, a_sh_n;
    logic [3:0] b_sh, b_sh_n;
    logic [1:0] cnt, cnt_n;
    logic [3:0] part, part_n;

    logic       busy_n;
    logic       done_n;
    logic [3:0] s_n;
    logic       bit_out_n;
    logic       bit_valid_n;
    logic [1:0] bit_idx_n;

`ifdef OR4_SERIAL_MSB_FIRST_EN
    function automatic logic head(input logic [3:0] v);
        return v[3];
    endfunction

    function automatic logic [3:0] advance(input logic [3:0] v);
        return {v[2:0], 1'b0};
    endfunction

    function automatic logic [1:0] pos(input logic [1:0] c);
        return ~c;
    endfunction
`else
    function automatic logic head(input logic [3:0] v);
        return v[0];
    endfunction

    function automatic logic [3:0] advance(input logic [3:0] v);
        return {1'b0, v[3:1]};
    endfunction

    function automatic logic [1:0] pos(input logic [1:0] c);
        return c;
    endfunction
`endif

    // State, datapath and output registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            a_sh          <= 4'd0;
            b_sh          <= 4'd0;
            cnt           <= 2'd0;
            part          <= 4'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.S         <= 4'd0;
            bus.bit_out   <= 1'b0;
            bus.bit_valid <= 1'b0;
            bus.bit_idx   <= 2'd0;
        end else begin
            state         <= state_n;
            a_sh          <= a_sh_n;
            b_sh          <= b_sh_n;
            cnt           <= cnt_n;
            part          <= part_n;
            bus.busy      <= busy_n;
            bus.done      <= done_n;
            bus.S         <= s_n;
            bus.bit_out   <= bit_out_n;
            bus.bit_valid <= bit_valid_n;
            bus.bit_idx   <= bit_idx_n;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle
    // ahead so that every port comes straight from a flop; the single OR
    // stage looks at the head of the shift registers as they will be.
    always_comb begin
        state_n     = state;
        a_sh_n      = a_sh;
        b_sh_n      = b_sh;
        cnt_n       = cnt;
        part_n      = part;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        s_n         = bus.S;
        bit_out_n   = 1'b0;
        bit_valid_n = 1'b0;
        bit_idx_n   = 2'd0;

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n     = RUN;
                    a_sh_n      = bus.A;
                    b_sh_n      = bus.B;
                    cnt_n       = 2'd0;
                    part_n      = 4'd0;
                    busy_n      = 1'b1;
                    bit_valid_n = 1'b1;
                    bit_idx_n   = pos(2'd0);
                    bit_out_n   = head(a_sh_n) | head(b_sh_n);
                end
            end

            RUN: begin
                busy_n                = 1'b1;
                part_n[bus.bit_idx]   = bus.bit_out;
                a_sh_n                = advance(a_sh);
                b_sh_n                = advance(b_sh);
                cnt_n                 = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    s_n     = part_n;
                end else begin
                    bit_valid_n = 1'b1;
                    bit_idx_n   = pos(cnt_n);
                    bit_out_n   = head(a_sh_n) | head(b_sh_n);
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_or4_serial_unit.sv
// Directed bench for or4_serial_unit with a cycle-phase reference model and
// a per-cycle compare process, plus literal expectations per scenario.
module tb_or4_serial_unit;

    logic clk;
    logic reset;
    or4_serial_unit_if bus();

    or4_serial_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phase k counts cycles since acceptance
    // (0 idle, 1..4 result bits, 5 done cycle).
    int         k = 0;
    logic [3:0] r = 4'd0;
    logic [3:0] s_exp = 4'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            k = 0;
            s_exp = 4'd0;
        end else if (k == 0) begin
            if (bus.start) begin
                r = bus.A | bus.B;
                k = 1;
            end
        end else if (k < 5) begin
            k = k + 1;
            if (k == 5) s_exp = r;
        end else begin
            k = 0;
        end
    end

    function automatic int exp_idx(input int ph);
        if (ph < 1 || ph > 4) return 0;
`ifdef OR4_SERIAL_MSB_FIRST_EN
        return 4 - ph;
`else
        return ph - 1;
`endif
    endfunction

    // Observation records used by the literal checks.
    int         done_cnt = 0;
    logic [3:0] bit_seq = 4'd0;
    logic [7:0] idx_seq = 8'd0;
    int         done_stamp[$];

    // Compare process: every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int  ei;
            logic [3:0] rr;
            rr = r;
            ei = exp_idx(k);
            check("busy",      int'(bus.busy),      (k >= 1 && k <= 5) ? 1 : 0);
            check("done",      int'(bus.done),      (k == 5) ? 1 : 0);
            check("S",         int'(bus.S),         int'(s_exp));
            check("bit_valid", int'(bus.bit_valid), (k >= 1 && k <= 4) ? 1 : 0);
            check("bit_idx",   int'(bus.bit_idx),   ei);
            check("bit_out",   int'(bus.bit_out),   (k >= 1 && k <= 4) ? int'(rr[ei]) : 0);
        end
        if (bus.done) begin
            done_cnt++;
            done_stamp.push_back(cyc);
        end
        if (bus.bit_valid) begin
            bit_seq = {bit_seq[2:0], bus.bit_out};
            idx_seq = {idx_seq[5:0], bus.bit_idx};
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        bus.start = 1'b1;
        bus.A = a;
        bus.B = b;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic clear_obs();
        done_cnt = 0;
        bit_seq = 4'd0;
        idx_seq = 8'd0;
        done_stamp.delete();
    endtask

    initial begin
        logic [3:0] exp_bits;
        logic [7:0] exp_idx_seq;

        reset = 1'b1;
        bus.start = 1'b0;
        bus.A = 4'd0;
        bus.B = 4'd0;
        step(2);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset from a running state, held two cycles.
        start_op(4'b1100, 4'b0011);
        step(1);
        clear_obs();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_S", int'(bus.S), 0);
        check("rst_valid", int'(bus.bit_valid), 0);
        step(6);
        check("rst_no_done", done_cnt, 0);

        // Basic run.
        clear_obs();
        start_op(4'b1010, 4'b0101);
        step(6);
        check("basic_S", int'(bus.S), 4'b1111);
        check("basic_bits", int'(bit_seq), 4'b1111);
        check("basic_dones", done_cnt, 1);

        // Bit order.
        clear_obs();
        start_op(4'b1000, 4'b0000);
        step(6);
`ifdef OR4_SERIAL_MSB_FIRST_EN
        exp_bits = 4'b1000;
        exp_idx_seq = 8'b11_10_01_00;
`else
        exp_bits = 4'b0001;
        exp_idx_seq = 8'b00_01_10_11;
`endif
        check("order_bits", int'(bit_seq), int'(exp_bits));
        check("order_idx", int'(idx_seq), int'(exp_idx_seq));
        check("order_S", int'(bus.S), 4'b1000);

        // Start while busy is ignored.
        clear_obs();
        start_op(4'b0011, 4'b0100);
        step(1);
        bus.start = 1'b1;
        bus.A = 4'b1111;
        step(1);
        bus.start = 1'b0;
        step(6);
        check("busy_rej_dones", done_cnt, 1);
        check("busy_rej_S", int'(bus.S), 4'b0111);

        // Reset mid-run.
        clear_obs();
        start_op(4'b0001, 4'b0010);
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_S", int'(bus.S), 0);
        step(6);
        check("midrst_no_done", done_cnt, 0);
        start_op(4'b0100, 4'b0000);
        step(6);
        check("midrst_S2", int'(bus.S), 4'b0100);
        check("midrst_dones", done_cnt, 1);

        // Reset and start together: reset wins.
        clear_obs();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.A = 4'b1111;
        step(1);
        reset = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", int'(bus.busy), 0);
        step(6);
        check("rst_start_dones", done_cnt, 0);
        check("rst_start_S", int'(bus.S), 0);

        // Back-to-back with start held.
        clear_obs();
        bus.start = 1'b1;
        bus.A = 4'b0001;
        bus.B = 4'b1000;
        step(18);
        bus.start = 1'b0;
        step(6);
        check("b2b_dones", done_cnt, 3);
        check("b2b_S", int'(bus.S), 4'b1001);
        if (done_stamp.size() == 3) begin
            check("b2b_gap1", done_stamp[1] - done_stamp[0], 6);
            check("b2b_gap2", done_stamp[2] - done_stamp[1], 6);
        end else begin
            check("b2b_stamps", done_stamp.size(), 3);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/or4_serial_unit.md
# or4_serial_unit

Bit-serial 4-bit OR unit: the sequential counterpart of the parallel 4-bit OR datapath. It latches two 4-bit operands on a start request and evaluates one bit pair per clock through a single 1-bit OR stage. Each result bit is streamed on a serial output with a valid strobe, and the assembled 4-bit result is presented on `S` with a one-cycle `done` pulse. It sits between operand-entry logic and display/result registers, where a serial result stream is needed.

## Interface
Parameters: none; width is fixed at 4 bits.

Ports (name, direction, width, meaning):
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  operation request; sampled only in IDLE
- `A`  input  4  operand A; sampled at the accepting edge
- `B`  input  4  operand B; sampled at the accepting edge
- `busy`  output  1  high from the cycle after acceptance through the done cycle
- `done`  output  1  one-cycle pulse when `S` is updated
- `S`  output  4  registered result `A|B`; holds until the next `done`
- `bit_out`  output  1  current serial result bit
- `bit_valid`  output  1  high while `bit_out` carries a result bit
- `bit_idx`  output  2  position in `S` of the current `bit_out`

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If `start`=1, load shift registers with `A` and `B`, clear the bit counter and the partial result, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, 4 cycles:
  - Each cycle: `bit_out` = OR of the current A/B shift-register bits, `bit_valid`=1, and `bit_idx` = the bit position.
  - The bit is written into the partial result at `bit_idx`; both shift registers advance.
  - The counter is 2 bits. On count 3, go to DONE; the counter wraps to 0 and is not reused.
- DONE, 1 cycle: `done`=1, `S` = full result, `bit_valid`=0; then go to IDLE.
- `start`, `A` and `B` are ignored outside IDLE, including in the DONE cycle. Operand changes during RUN have no effect.
- `S` changes only in the DONE cycle or on reset. Partial results are never visible on `S`.
- Reset, in any state:
  - Next cycle: state = IDLE.
  - All outputs are 0: `busy`, `done`, `S`, `bit_out`, `bit_valid`, `bit_idx`.
  - Shift registers and the partial result are cleared; any in-flight operation is discarded with no `done`.
- If `reset` and `start` are high in the same cycle, reset wins and `start` is dropped.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Let N be the cycle in which `start`=1 is sampled in IDLE:
  - Cycles N+1..N+4: RUN; `busy`=1, `bit_valid`=1, one result bit per cycle.
  - Cycle N+5: DONE; `busy`=1, `done`=1, new `S` valid.
  - Cycle N+6: IDLE; `busy`=0, and a new `start` is accepted here.
- Latency from start to done is 5 cycles. Minimum issue interval is 6 cycles; a continuously held `start` yields one operation every 6 cycles.
- While `bit_valid`=0, `bit_out` and `bit_idx` are 0.

## Configuration
- Macro `OR4_SERIAL_MSB_FIRST_EN`:
  - Defined: bits are processed MSB-first; `bit_idx` sequence is 3,2,1,0.
  - Undefined (default): bits are processed LSB-first; `bit_idx` sequence is 0,1,2,3.
- `S`, the latency and the handshake are identical in both builds.

## Test plan
- Reset check: assert `reset` for 2 cycles from an arbitrary state -> all outputs 0, `busy`=0, no `done`.
- Basic run: `A`=4'b1010, `B`=4'b0101, `start` pulse -> `bit_out`=1,1,1,1 on N+1..N+4; `done` at N+5; `S`=4'b1111.
- Bit order: `A`=4'b1000, `B`=4'b0000:
  - Default build -> `bit_out` 0,0,0,1 with `bit_idx` 0..3.
  - With `OR4_SERIAL_MSB_FIRST_EN` -> `bit_out` 1,0,0,0 with `bit_idx` 3..0.
  - Both builds -> `S`=4'b1000.
- Busy rejection: start with `A`=4'b0011, `B`=4'b0100; at N+2 pulse `start` with `A`=4'b1111 -> exactly one `done`, `S`=4'b0111.
- Reset mid-run: start with `A`=4'b0001, `B`=4'b0010; assert `reset` at N+2 -> IDLE at N+3, `S`=0, no `done`. A following start with `A`=4'b0100, `B`=4'b0000 gives `S`=4'b0100.
- Back-to-back: hold `start`=1 with `A`=4'b0001, `B`=4'b1000 -> `done` at N+5, N+11, N+17; `S`=4'b1001 each time.
